// File: rtl/clock_pkg.sv
// Shared definitions for the 24 h clock: set-mode encoding and BCD digit limits.
// Used by clock_time_ctrl and the per-digit display decoders.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_SET_H = 2'd1,
    MODE_SET_M = 2'd2
  } mode_e;

  localparam logic [3:0] SEC_T_MAX     = 4'd5;
  localparam logic [3:0] MIN_T_MAX     = 4'd5;
  localparam logic [3:0] HR_T_MAX      = 4'd2;
  localparam logic [3:0] HR_U_MAX_AT_2 = 4'd3;
  localparam logic [3:0] UNIT_MAX      = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit counter: increments on inc, wraps to 0 after max, and reports
// a carry in the same cycle as the wrapping increment.
module bcd_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  input  logic [3:0] max,
  output logic [3:0] value,
  output logic       carry
);

  logic at_max;

  // ">=" rather than "==" so a digit can never sit above its limit
  assign at_max = (value >= max);
  assign carry  = inc & at_max;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= 4'd0;
    end else if (inc) begin
      value <= at_max ? 4'd0 : value + 4'd1;
    end
  end

endmodule

// File: rtl/clock_time_ctrl.sv
// 24 h HH:MM:SS timekeeper: 1 Hz prescaler, BCD cascade and RUN/SET_H/SET_M set-mode FSM.
// Optional CLOCK_BLINK_EN macro adds blinking of the field being edited via digit_blank.
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BLINK_DIV = CLK_HZ / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] h_t,
  output logic [3:0] h_u,
  output logic [3:0] m_t,
  output logic [3:0] m_u,
  output logic [3:0] s_t,
  output logic [3:0] s_u,
  output logic [5:0] digit_blank,
  output logic [1:0] mode,
  output logic       sec_tick
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  localparam logic [1:0] ST_RUN   = MODE_RUN;
  localparam logic [1:0] ST_SET_H = MODE_SET_H;
  localparam logic [1:0] ST_SET_M = MODE_SET_M;

  logic [1:0]    state;
  logic [PW-1:0] presc;
  logic          mode_q, inc_q, rst_q;
  logic          mode_press, inc_press;
  logic          in_run, presc_wrap, clr_sec;
  logic          min_inc, hr_inc;
  logic          s_u_c, s_t_c, m_u_c, m_t_c, h_u_c;
  logic          unused_h_t_c;
  logic [3:0]    h_u_max;

  // rst_q suppresses a false press from a button already held through reset
  assign mode_press = btn_mode & ~mode_q & ~rst_q;
  assign inc_press  = btn_inc & ~inc_q & ~rst_q & ~mode_press;

  assign in_run     = (state == ST_RUN);
  assign presc_wrap = (presc == PW'(CLK_HZ - 1));
  assign sec_tick   = in_run & presc_wrap;
  assign mode       = state;

  assign clr_sec = mode_press & (state == ST_SET_M);
  assign min_inc = (in_run & s_t_c) | (inc_press & (state == ST_SET_M));
  assign hr_inc  = (in_run & m_t_c) | (inc_press & (state == ST_SET_H));
  assign h_u_max = (h_t == HR_T_MAX) ? HR_U_MAX_AT_2 : UNIT_MAX;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RUN;
      presc  <= '0;
      mode_q <= 1'b0;
      inc_q  <= 1'b0;
      rst_q  <= 1'b1;
    end else begin
      rst_q  <= 1'b0;
      mode_q <= btn_mode;
      inc_q  <= btn_inc;
      if (!in_run || presc_wrap) begin
        presc <= '0;
      end else begin
        presc <= presc + PW'(1);
      end
      if (mode_press) begin
        case (state)
          ST_RUN:   state <= ST_SET_H;
          ST_SET_H: state <= ST_SET_M;
          default:  state <= ST_RUN;
        endcase
      end
    end
  end

  bcd_digit u_s_u (.clk(clk), .rst(rst), .inc(sec_tick), .clr(clr_sec), .max(UNIT_MAX),
                   .value(s_u), .carry(s_u_c));
  bcd_digit u_s_t (.clk(clk), .rst(rst), .inc(s_u_c), .clr(clr_sec), .max(SEC_T_MAX),
                   .value(s_t), .carry(s_t_c));
  bcd_digit u_m_u (.clk(clk), .rst(rst), .inc(min_inc), .clr(1'b0), .max(UNIT_MAX),
                   .value(m_u), .carry(m_u_c));
  bcd_digit u_m_t (.clk(clk), .rst(rst), .inc(m_u_c), .clr(1'b0), .max(MIN_T_MAX),
                   .value(m_t), .carry(m_t_c));
  // 23 -> 00 falls out of h_u wrapping at 3 and h_t wrapping at 2 together
  bcd_digit u_h_u (.clk(clk), .rst(rst), .inc(hr_inc), .clr(1'b0), .max(h_u_max),
                   .value(h_u), .carry(h_u_c));
  bcd_digit u_h_t (.clk(clk), .rst(rst), .inc(h_u_c), .clr(1'b0), .max(HR_T_MAX),
                   .value(h_t), .carry(unused_h_t_c));

`ifdef CLOCK_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  // restarting on every transition keeps the newly edited field visible first
  always_ff @(posedge clk) begin
    if (rst || mode_press) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  always_comb begin
    digit_blank = 6'b0;
    case (state)
      ST_SET_H: digit_blank = {blink_phase, blink_phase, 4'b0};
      ST_SET_M: digit_blank = {2'b0, blink_phase, blink_phase, 2'b0};
      default:  digit_blank = 6'b0;
    endcase
  end
`else
  logic unused_blink_div;
  assign unused_blink_div = (BLINK_DIV == 0);
  assign digit_blank      = 6'b0;
`endif

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl (CLK_HZ=4, BLINK_DIV=2) with a time-of-day
// reference model compared every cycle plus hand-computed literal checkpoints.
module tb_clock_time_ctrl;

  localparam int CLK_HZ    = 4;
  localparam int BLINK_DIV = 2;

  logic       clk, rst, btn_mode, btn_inc;
  logic [3:0] h_t, h_u, m_t, m_u, s_t, s_u;
  logic [5:0] digit_blank;
  logic [1:0] mode;
  logic       sec_tick;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];

  clock_time_ctrl #(.CLK_HZ(CLK_HZ), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .h_t(h_t), .h_u(h_u), .m_t(m_t), .m_u(m_u), .s_t(s_t), .s_u(s_u),
    .digit_blank(digit_blank), .mode(mode), .sec_tick(sec_tick)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] pack_time(int h, int m, int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  logic [23:0] dut_time;
  assign dut_time = {h_t, h_u, m_t, m_u, s_t, s_u};

  // reference model: whole-number time of day plus mode and seconds phase
  int mh, mm, ms, mmode, mphase_cnt, mbcnt;
  bit mprev_mode, mprev_inc, mblink, valid;
  bit mp, ip;
  logic [5:0] exp_blank;
  logic       exp_tick;

  initial valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mh = 0; mm = 0; ms = 0; mmode = 0; mphase_cnt = 0; mbcnt = 0; mblink = 1'b0;
      mprev_mode = btn_mode;
      mprev_inc  = btn_inc;
      valid      = 1'b1;
    end else if (valid) begin
      mp = btn_mode && !mprev_mode;
      ip = btn_inc && !mprev_inc && !mp;
      if (mmode == 0) begin
        if (mphase_cnt == CLK_HZ - 1) begin
          mphase_cnt = 0;
          ms = ms + 1;
          if (ms == 60) begin
            ms = 0; mm = mm + 1;
            if (mm == 60) begin
              mm = 0; mh = (mh + 1) % 24;
            end
          end
        end else begin
          mphase_cnt = mphase_cnt + 1;
        end
      end else begin
        mphase_cnt = 0;
      end
      if (mp) begin
        if (mmode == 2) ms = 0;
        mmode = (mmode + 1) % 3;
        mbcnt = 0; mblink = 1'b0;
      end else begin
        if (ip && mmode == 1) mh = (mh + 1) % 24;
        if (ip && mmode == 2) mm = (mm + 1) % 60;
        if (mbcnt == BLINK_DIV - 1) begin
          mbcnt = 0; mblink = !mblink;
        end else begin
          mbcnt = mbcnt + 1;
        end
      end
      mprev_mode = btn_mode;
      mprev_inc  = btn_inc;
    end
    #1;
    if (valid) begin
      exp_tick  = (mmode == 0) && (mphase_cnt == CLK_HZ - 1);
      exp_blank = 6'b0;
`ifdef CLOCK_BLINK_EN
      if (mmode == 1) exp_blank = {mblink, mblink, 4'b0};
      if (mmode == 2) exp_blank = {2'b0, mblink, mblink, 2'b0};
`endif
      checks++;
      if (dut_time !== pack_time(mh, mm, ms)) begin
        errors++;
        $display("FAIL model_time got %h exp %h at %0t", dut_time, pack_time(mh, mm, ms), $time);
      end
      checks++;
      if (mode !== 2'(mmode)) begin
        errors++;
        $display("FAIL model_mode got %0d exp %0d at %0t", mode, mmode, $time);
      end
      checks++;
      if (sec_tick !== exp_tick) begin
        errors++;
        $display("FAIL model_tick got %b exp %b at %0t", sec_tick, exp_tick, $time);
      end
      checks++;
      if (digit_blank !== exp_blank) begin
        errors++;
        $display("FAIL model_blank got %b exp %b at %0t", digit_blank, exp_blank, $time);
      end
    end
  end

  // driver tasks (inputs change on the falling edge)
  task automatic press_mode();
    btn_mode = 1'b1;
    @(negedge clk);
    btn_mode = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      btn_inc = 1'b1;
      @(negedge clk);
      btn_inc = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_sec();
    int k = 0;
    while (!sec_tick && k < 4 * CLK_HZ) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!sec_tick) begin
      errors++;
      $display("FAIL wait_sec_timeout got no tick exp tick within %0d cycles", 4 * CLK_HZ);
    end
    @(negedge clk);
  endtask

  // scoreboard: literal time checkpoints in order
  task automatic check_time(input string name, input logic [23:0] mask);
    logic [23:0] exp;
    exp = exp_q.pop_front();
    checks++;
    if ((dut_time & mask) !== (exp & mask)) begin
      errors++;
      $display("FAIL %s got %h exp %h (mask %h)", name, dut_time, exp, mask);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  initial begin
    logic [23:0] lits [15];
    int ticks;
    lits = '{24'h000000, 24'h000001, 24'h235900, 24'h235900, 24'h235958,
             24'h235959, 24'h000000, 24'h010000, 24'h010700, 24'h010000,
             24'h010000, 24'h010000, 24'h020000, 24'h123400, 24'h000000};
    foreach (lits[i]) exp_q.push_back(lits[i]);

    rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (3) @(negedge clk);
    check_time("reset_time", 24'hFFFFFF);
    check_val("reset_mode", int'(mode), 0);
    check_val("reset_blank", int'(digit_blank), 0);

    // first second after reset: one tick in four cycles, s_u=1 next cycle
    rst = 1'b0;
    ticks = 0;
    for (int i = 0; i < 4; i++) begin
      if (sec_tick) ticks++;
      @(negedge clk);
    end
    check_val("first_tick_count", ticks, 1);
    check_time("first_second", 24'hFFFFFF);

    // load 23:59 and run to 23:59:58, then through midnight
    press_mode();
    press_inc(23);
    press_mode();
    press_inc(59);
    check_val("set_m_mode", int'(mode), 2);
    check_time("set_2359", 24'hFFFF00);
    press_mode();
    check_time("exit_clears_sec", 24'hFFFFFF);
    for (int i = 0; i < 58; i++) wait_sec();
    check_time("at_235958", 24'hFFFFFF);
    wait_sec();
    check_time("at_235959", 24'hFFFFFF);
    wait_sec();
    check_time("midnight_wrap", 24'hFFFFFF);

    // 25 hour increments wrap past 24
    press_mode();
    press_inc(25);
    check_val("set_h_mode", int'(mode), 1);
    check_time("hours_25_inc", 24'hFFFFFF);

    // 60 minute increments return to 00 without touching hours
    press_mode();
    press_inc(7);
    check_time("min_7_inc", 24'hFFFFFF);
    press_inc(53);
    check_time("min_60_inc", 24'hFFFFFF);
    press_mode();
    check_val("back_to_run", int'(mode), 0);
    check_time("run_sec_00", 24'hFFFFFF);

    // mode+inc together in RUN, held 10 cycles
    btn_mode = 1'b1; btn_inc = 1'b1;
    repeat (10) @(negedge clk);
    btn_mode = 1'b0; btn_inc = 1'b0;
    @(negedge clk);
    check_val("simul_mode", int'(mode), 1);
    check_time("simul_hours", 24'hFF0000);
    btn_inc = 1'b1;
    repeat (10) @(negedge clk);
    btn_inc = 1'b0;
    @(negedge clk);
    check_time("held_inc_once", 24'hFF0000);

    // 12:34 in SET_M, then reset with buttons held
    press_inc(10);
    press_mode();
    press_inc(34);
    check_val("pre_reset_mode", int'(mode), 2);
    check_time("at_1234", 24'hFFFF00);
    btn_mode = 1'b1; btn_inc = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_time("mid_reset_time", 24'hFFFFFF);
    check_val("mid_reset_mode", int'(mode), 0);
    check_val("mid_reset_blank", int'(digit_blank), 0);
    repeat (5) @(negedge clk);
    check_val("held_no_press", int'(mode), 0);
    btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
